cap_board_encoder: RTL and testbench
====================================

CAP_BOARD_ENCODER -- requirements
Module: cap_board_encoder

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 4, clk cycles the code is stable before the enable rises.
REQ-002 SHALL have parameter STROBE_CYC, default 8, clk cycles the enable stays high.
REQ-003 SHALL have parameter HOLD_CYC, default 4, clk cycles the code is held after the enable falls.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports: clk in 1, 2 MHz system clock; rst in 1, async active-high reset.
REQ-005 SHALL have port req_valid in 1, new target request.
REQ-006 SHALL have port req_ready out 1, high only in IDLE.
REQ-007 SHALL have ports req_ser and req_par, each in 7, target serial and parallel tuning codes.
REQ-008 SHALL have ports tuningCodeSer and tuningCodePar, each out 7, registered code buses to the cap boards.
REQ-009 SHALL have ports enableSer and enablePar, each out 1, registered strobes to the cap boards.
REQ-010 SHALL have port busy out 1, high in any state other than IDLE.
REQ-011 SHALL have port done out 1, one-cycle pulse when a request completes.

Function
REQ-012 SHALL use FSM states IDLE, SETUP, STROBE and HOLD, all outputs registered.
REQ-013 SHALL perform a handshake when req_valid and req_ready are both high on a rising clk edge, capturing req_ser and req_par into target registers tgtSer and tgtPar.
REQ-014 SHALL ignore req_valid when req_ready is low, with no queueing.
REQ-015 SHALL, on handshake, compute next step codes nxtSer and nxtPar (see REQ-027 and REQ-028) and set chgSer = (nxtSer != tuningCodeSer) and chgPar = (nxtPar != tuningCodePar).
REQ-016 SHALL, if neither chgSer nor chgPar is set, stay in IDLE and pulse done on the next cycle, with no enable activity.
REQ-017 SHALL, otherwise, load the changed buses with the next codes, leave unchanged buses untouched, and enter SETUP.
REQ-018 SHALL remain in SETUP for SETUP_CYC cycles, then enter STROBE.
REQ-019 SHALL, in STROBE, hold enableSer = chgSer and enablePar = chgPar for exactly STROBE_CYC cycles, then enter HOLD.
REQ-020 SHALL deassert both enables for the entire HOLD state.
REQ-021 SHALL keep the code buses constant from SETUP entry through HOLD exit.
REQ-022 SHALL remain in HOLD for HOLD_CYC cycles, then either enter SETUP with the next step (REQ-027) or go to IDLE and pulse done.
REQ-023 SHALL use an 8-bit down-counter for each timed state, reloaded on state entry, with a parameter value of 0 treated as 1.
REQ-024 SHALL take exactly 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC cycles from handshake to done for one step: 17 with defaults.
REQ-025 SHALL never drive an enable high in the same cycle its code bus changes.
REQ-026 SHALL perform 7-bit unsigned comparisons on the codes, with no wrap-around: codes 0 and 127 are endpoints.

Configuration
REQ-027 SHALL, with macro CAP_ENC_SLEW_EN defined, set nxt = cur + 1 if tgt > cur, cur - 1 if tgt < cur, else cur, independently per side; transactions repeat (HOLD to SETUP) until both buses equal target, and done pulses once, after the last HOLD.
REQ-028 SHALL, with CAP_ENC_SLEW_EN undefined, set nxt = tgt, so each request completes in at most one transaction.

Reset
REQ-029 SHALL, while rst is high, asynchronously force state to IDLE, tuningCodeSer and tuningCodePar to 0, enableSer, enablePar, busy and done to 0, tgtSer, tgtPar and all counters to 0, and req_ready to 1.
REQ-030 SHALL, on reset asserted mid-transaction, drop the enables immediately, not complete the transaction, and not pulse done.

Verification
REQ-031 SHALL verify a single step with slew disabled: from reset, request ser=5, par=0 -> tuningCodeSer=5 on cycle 1, enableSer high during cycles 5-12, enablePar never high, done on cycle 17.
REQ-032 SHALL verify a null request: request ser=0, par=0 immediately after reset -> no enable activity, done on the next cycle, busy stays 0.
REQ-033 SHALL verify slew: with CAP_ENC_SLEW_EN defined, from codes ser=3, par=3, request ser=5, par=2 -> transaction 1 sets ser=4, par=2 with both enables strobed; transaction 2 sets ser=5 with enableSer only; one done after 34 cycles.
REQ-034 SHALL verify an ignored request: pulse req_valid with ser=9 while busy -> ignored; target and codes unaffected.
REQ-035 SHALL verify reset mid-STROBE: assert rst during STROBE -> enables are 0 in the same cycle, codes are 0, no done, and req_ready is 1 after release.
REQ-036 SHALL verify endpoints and a zero parameter: with STROBE_CYC=0, request ser=127 -> enable high for exactly 1 cycle and tuningCodeSer=127 with no overflow.

Source files
------------

// File: rtl/cap_board_encoder_if.sv
// Request handshake and cap-board code/strobe bus for cap_board_encoder.
// The encoder uses the slave modport; the requester uses the master modport.
interface cap_board_encoder_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_ser;
    logic [6:0] req_par;
    logic [6:0] tuningCodeSer;
    logic [6:0] tuningCodePar;
    logic       enableSer;
    logic       enablePar;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_ser, req_par,
        input  req_ready, tuningCodeSer, tuningCodePar, enableSer, enablePar, busy, done
    );

    modport slave (
        input  req_valid, req_ser, req_par,
        output req_ready, tuningCodeSer, tuningCodePar, enableSer, enablePar, busy, done
    );
endinterface

// File: rtl/cap_board_encoder.sv
// Drives serial/parallel cap-board tuning codes with setup/strobe/hold timing.
// Optional macro CAP_ENC_SLEW_EN: step each code by one LSB per transaction toward the target.
module cap_board_encoder #(
    parameter int SETUP_CYC  = 4,
    parameter int STROBE_CYC = 8,
    parameter int HOLD_CYC   = 4
) (
    input  logic                clk,
    input  logic                rst,
    cap_board_encoder_if.slave  bus,
    output logic [1:0]          o_dbg_state
);

    // Handshake: a request is taken on a rising clk edge where req_valid and
    // req_ready are both high; req_valid while req_ready is low is dropped.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Counter reload values; a zero-cycle parameter still lasts one cycle.
    localparam logic [7:0] SETUP_LD  = (SETUP_CYC  == 0) ? 8'd0 : 8'(SETUP_CYC  - 1);
    localparam logic [7:0] STROBE_LD = (STROBE_CYC == 0) ? 8'd0 : 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD   = (HOLD_CYC   == 0) ? 8'd0 : 8'(HOLD_CYC   - 1);

    state_t     r_state,    w_state;
    logic [7:0] r_cnt,      w_cnt;
    logic       r_pend,     w_pend;
    logic [6:0] r_tgt_ser,  w_tgt_ser;
    logic [6:0] r_tgt_par,  w_tgt_par;
    logic [6:0] r_code_ser, w_code_ser;
    logic [6:0] r_code_par, w_code_par;
    logic       r_chg_ser,  w_chg_ser;
    logic       r_chg_par,  w_chg_par;
    logic       r_en_ser,   w_en_ser;
    logic       r_en_par,   w_en_par;
    logic       r_busy,     w_busy;
    logic       r_done,     w_done;
    logic       r_ready,    w_ready;

    logic [6:0] w_nxt_ser;
    logic [6:0] w_nxt_par;
    logic       w_more;

    always_comb begin
`ifdef CAP_ENC_SLEW_EN
        w_nxt_ser = (r_tgt_ser > r_code_ser) ? r_code_ser + 7'd1 :
                    (r_tgt_ser < r_code_ser) ? r_code_ser - 7'd1 : r_code_ser;
        w_nxt_par = (r_tgt_par > r_code_par) ? r_code_par + 7'd1 :
                    (r_tgt_par < r_code_par) ? r_code_par - 7'd1 : r_code_par;
        w_more    = (r_code_ser != r_tgt_ser) || (r_code_par != r_tgt_par);
`else
        w_nxt_ser = r_tgt_ser;
        w_nxt_par = r_tgt_par;
        w_more    = 1'b0;
`endif
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_pend     = r_pend;
        w_tgt_ser  = r_tgt_ser;
        w_tgt_par  = r_tgt_par;
        w_code_ser = r_code_ser;
        w_code_par = r_code_par;
        w_chg_ser  = r_chg_ser;
        w_chg_par  = r_chg_par;
        w_en_ser   = r_en_ser;
        w_en_par   = r_en_par;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_ready    = r_ready;

        case (r_state)
            IDLE: begin
                // r_pend marks the evaluation cycle that follows a handshake
                // or a finished slew step: load a step or report completion.
                if (r_pend) begin
                    w_pend = 1'b0;
                    if ((w_nxt_ser != r_code_ser) || (w_nxt_par != r_code_par)) begin
                        w_code_ser = w_nxt_ser;
                        w_code_par = w_nxt_par;
                        w_chg_ser  = (w_nxt_ser != r_code_ser);
                        w_chg_par  = (w_nxt_par != r_code_par);
                        w_state    = SETUP;
                        w_cnt      = SETUP_LD;
                        w_busy     = 1'b1;
                    end else begin
                        w_done  = 1'b1;
                        w_ready = 1'b1;
                    end
                end else if (bus.req_valid && r_ready) begin
                    w_tgt_ser = bus.req_ser;
                    w_tgt_par = bus.req_par;
                    w_pend    = 1'b1;
                    w_ready   = 1'b0;
                end
            end
            SETUP: begin
                if (r_cnt == 8'd0) begin
                    w_state  = STROBE;
                    w_cnt    = STROBE_LD;
                    w_en_ser = r_chg_ser;
                    w_en_par = r_chg_par;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            STROBE: begin
                if (r_cnt == 8'd0) begin
                    w_state  = HOLD;
                    w_cnt    = HOLD_LD;
                    w_en_ser = 1'b0;
                    w_en_par = 1'b0;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            HOLD: begin
                if (r_cnt == 8'd0) begin
                    w_state = IDLE;
                    w_busy  = 1'b0;
                    if (w_more) begin
                        w_pend = 1'b1;
                    end else begin
                        w_done  = 1'b1;
                        w_ready = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state  = IDLE;
                w_en_ser = 1'b0;
                w_en_par = 1'b0;
                w_busy   = 1'b0;
                w_ready  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_pend     <= 1'b0;
            r_tgt_ser  <= 7'd0;
            r_tgt_par  <= 7'd0;
            r_code_ser <= 7'd0;
            r_code_par <= 7'd0;
            r_chg_ser  <= 1'b0;
            r_chg_par  <= 1'b0;
            r_en_ser   <= 1'b0;
            r_en_par   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_pend     <= w_pend;
            r_tgt_ser  <= w_tgt_ser;
            r_tgt_par  <= w_tgt_par;
            r_code_ser <= w_code_ser;
            r_code_par <= w_code_par;
            r_chg_ser  <= w_chg_ser;
            r_chg_par  <= w_chg_par;
            r_en_ser   <= w_en_ser;
            r_en_par   <= w_en_par;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_ready    <= w_ready;
        end
    end

    assign bus.req_ready     = r_ready;
    assign bus.tuningCodeSer = r_code_ser;
    assign bus.tuningCodePar = r_code_par;
    assign bus.enableSer     = r_en_ser;
    assign bus.enablePar     = r_en_par;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_cap_board_encoder.sv
// Self-checking bench for cap_board_encoder: directed timing scenarios plus
// randomized back-to-back requests checked against a step/timeline model.
module tb_cap_board_encoder;

    localparam int S  = 4;
    localparam int ST = 8;
    localparam int H  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state_z;

    int checks = 0;
    int errors = 0;

    cap_board_encoder_if bus();
    cap_board_encoder_if bz();

    cap_board_encoder #(.SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H)) dut (
        .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
    );

    cap_board_encoder #(.SETUP_CYC(S), .STROBE_CYC(0), .HOLD_CYC(H)) dut_z (
        .clk(clk), .rst(rst), .bus(bz), .o_dbg_state(dbg_state_z)
    );

    always #5 clk = ~clk;

    // Reference model: current codes and the list of code steps a request needs.
    logic [6:0] m_ser = 7'd0;
    logic [6:0] m_par = 7'd0;
    logic [6:0] q_s[$];
    logic [6:0] q_p[$];
    logic       q_cs[$];
    logic       q_cp[$];

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic void plan(input logic [6:0] cs, input logic [6:0] cp,
                                 input logic [6:0] ts, input logic [6:0] tp);
        q_s.delete(); q_p.delete(); q_cs.delete(); q_cp.delete();
`ifdef CAP_ENC_SLEW_EN
        while ((cs != ts) || (cp != tp)) begin
            logic [6:0] ns;
            logic [6:0] np;
            ns = (ts > cs) ? cs + 7'd1 : (ts < cs) ? cs - 7'd1 : cs;
            np = (tp > cp) ? cp + 7'd1 : (tp < cp) ? cp - 7'd1 : cp;
            q_s.push_back(ns); q_p.push_back(np);
            q_cs.push_back(ns != cs); q_cp.push_back(np != cp);
            cs = ns; cp = np;
        end
`else
        if ((cs != ts) || (cp != tp)) begin
            q_s.push_back(ts); q_p.push_back(tp);
            q_cs.push_back(ts != cs); q_cp.push_back(tp != cp);
        end
`endif
    endfunction

    // Expected {codeSer, codePar, enSer, enPar, done} o cycles after the handshake edge.
    function automatic logic [16:0] expect_at(input int o, input int s, input int st, input int h,
                                              input logic [6:0] c0s, input logic [6:0] c0p);
        int len;
        int n;
        logic [6:0] cs;
        logic [6:0] cp;
        logic es;
        logic ep;
        logic dn;
        len = 1 + eff(s) + eff(st) + eff(h);
        n = q_s.size();
        cs = c0s; cp = c0p; es = 1'b0; ep = 1'b0;
        if (n == 0) begin
            dn = (o == 1);
        end else begin
            for (int k = 0; k < n; k++) begin
                if (o >= k * len + 1) begin
                    cs = q_s[k]; cp = q_p[k];
                end
                if ((o >= k * len + 1 + eff(s)) && (o <= k * len + eff(s) + eff(st))) begin
                    es = q_cs[k]; ep = q_cp[k];
                end
            end
            dn = (o == n * len);
        end
        return {cs, cp, es, ep, dn};
    endfunction

    function automatic logic [6:0] near(input logic [6:0] c);
        int v;
`ifdef CAP_ENC_SLEW_EN
        v = int'(c) + int'($urandom_range(0, 4)) - 2;
`else
        v = int'($urandom_range(0, 127));
`endif
        if (v < 0) v = 0;
        if (v > 127) v = 127;
        return 7'(v);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.tuningCodeSer, bus.tuningCodePar, bus.enableSer, bus.enablePar, bus.busy, bus.done, bus.req_ready, dbg_state}
            !== {7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL reset_main got %h exp %h",
                {bus.tuningCodeSer, bus.tuningCodePar, bus.enableSer, bus.enablePar, bus.busy, bus.done, bus.req_ready, dbg_state},
                {7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0});
        end
        checks++;
        if ({bz.tuningCodeSer, bz.tuningCodePar, bz.enableSer, bz.enablePar, bz.busy, bz.done, bz.req_ready}
            !== {7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_zero got %h exp %h",
                {bz.tuningCodeSer, bz.tuningCodePar, bz.enableSer, bz.enablePar, bz.busy, bz.done, bz.req_ready},
                {7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        rst = 1'b0;
    endtask

    task automatic test_null();
        logic [17:0] got;
        logic [17:0] exp;
        bus.req_ser = 7'd0; bus.req_par = 7'd0; bus.req_valid = 1'b1;
        for (int o = 0; o <= 3; o++) begin
            @(negedge clk);
            if (o == 0) bus.req_valid = 1'b0;
            got = {bus.tuningCodeSer, bus.tuningCodePar, bus.enableSer, bus.enablePar, bus.done, bus.busy};
            exp = {7'd0, 7'd0, 1'b0, 1'b0, (o == 1), 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL null cyc%0d got %h exp %h", o, got, exp);
            end
        end
    endtask

    task automatic test_single_step();
        logic [6:0] ts;
        logic [17:0] got;
        logic [17:0] exp;
`ifdef CAP_ENC_SLEW_EN
        ts = 7'd1;
`else
        ts = 7'd5;
`endif
        bus.req_ser = ts; bus.req_par = 7'd0; bus.req_valid = 1'b1;
        for (int o = 0; o <= 19; o++) begin
            @(negedge clk);
            if (o == 0) bus.req_valid = 1'b0;
            got = {bus.tuningCodeSer, bus.tuningCodePar, bus.enableSer, bus.enablePar, bus.done, bus.busy};
            exp = {(o >= 1) ? ts : 7'd0, 7'd0, (o >= 5 && o <= 12), 1'b0, (o == 17), (o >= 1 && o <= 16)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single cyc%0d got %h exp %h", o, got, exp);
            end
        end
        m_ser = ts; m_par = 7'd0;
    endtask

    task automatic test_ignored();
        logic [6:0] ts;
        logic [16:0] got;
        logic [16:0] exp;
        int len;
        len = 1 + eff(S) + eff(ST) + eff(H);
        ts = (m_ser < 7'd127) ? m_ser + 7'd1 : m_ser - 7'd1;
        plan(m_ser, m_par, ts, m_par);
        bus.req_ser = ts; bus.req_par = m_par; bus.req_valid = 1'b1;
        for (int o = 0; o <= len + 6; o++) begin
            @(negedge clk);
            if (o == 0) bus.req_valid = 1'b0;
            if (o == 7) bus.req_valid = 1'b0;
            got = {bus.tuningCodeSer, bus.tuningCodePar, bus.enableSer, bus.enablePar, bus.done};
            exp = expect_at(o, S, ST, H, m_ser, m_par);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ignored cyc%0d got %h exp %h", o, got, exp);
            end
            if (o == 6) begin
                checks++;
                if (bus.req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ignored_ready got %b exp 0", bus.req_ready);
                end
                bus.req_ser = 7'd9; bus.req_par = 7'd9; bus.req_valid = 1'b1;
            end
        end
        checks++;
        if ({bus.busy, bus.req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL ignored_idle got %b exp 01", {bus.busy, bus.req_ready});
        end
        m_par = m_par; m_ser = ts;
    endtask

`ifdef CAP_ENC_SLEW_EN
    task automatic test_slew();
        logic [16:0] got;
        logic [16:0] exp;
        int last;
        plan(m_ser, m_par, 7'd3, 7'd3);
        last = (q_s.size() == 0) ? 1 : q_s.size() * (1 + S + ST + H);
        bus.req_ser = 7'd3; bus.req_par = 7'd3; bus.req_valid = 1'b1;
        for (int o = 0; o <= last; o++) begin
            @(negedge clk);
            if (o == 0) bus.req_valid = 1'b0;
            got = {bus.tuningCodeSer, bus.tuningCodePar, bus.enableSer, bus.enablePar, bus.done};
            exp = expect_at(o, S, ST, H, m_ser, m_par);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL slew_prep cyc%0d got %h exp %h", o, got, exp);
            end
        end
        bus.req_ser = 7'd5; bus.req_par = 7'd2; bus.req_valid = 1'b1;
        for (int o = 0; o <= 36; o++) begin
            @(negedge clk);
            if (o == 0) bus.req_valid = 1'b0;
            got = {bus.tuningCodeSer, bus.tuningCodePar, bus.enableSer, bus.enablePar, bus.done};
            exp = {(o >= 18) ? 7'd5 : (o >= 1) ? 7'd4 : 7'd3, (o >= 1) ? 7'd2 : 7'd3,
                   (o >= 5 && o <= 12) || (o >= 22 && o <= 29), (o >= 5 && o <= 12), (o == 34)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL slew cyc%0d got %h exp %h", o, got, exp);
            end
        end
        m_ser = 7'd5; m_par = 7'd2;
    endtask
`endif

    task automatic test_back_to_back();
        logic [6:0] ts;
        logic [6:0] tp;
        logic [16:0] got;
        logic [16:0] exp;
        int last;
        for (int i = 0; i < 12; i++) begin
            ts = near(m_ser);
            tp = near(m_par);
            if (i == 3) ts = 7'd127;
            if (i == 4) tp = 7'd0;
            if ($urandom_range(0, 3) == 0) begin
                ts = m_ser; tp = m_par;
            end
            plan(m_ser, m_par, ts, tp);
            last = (q_s.size() == 0) ? 1 : q_s.size() * (1 + S + ST + H);
            checks++;
            if (bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d got %b exp 1", i, bus.req_ready);
            end
            bus.req_ser = ts; bus.req_par = tp; bus.req_valid = 1'b1;
            for (int o = 0; o <= last; o++) begin
                @(negedge clk);
                if (o == 0) bus.req_valid = 1'b0;
                got = {bus.tuningCodeSer, bus.tuningCodePar, bus.enableSer, bus.enablePar, bus.done};
                exp = expect_at(o, S, ST, H, m_ser, m_par);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL b2b_%0d cyc%0d got %h exp %h", i, o, got, exp);
                end
            end
            m_ser = ts; m_par = tp;
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_idle got %b exp 001", {bus.busy, bus.done, bus.req_ready});
        end
    endtask

    task automatic test_reset_mid_strobe();
        logic [6:0] ts;
        logic [17:0] got;
        ts = (m_ser < 7'd127) ? m_ser + 7'd1 : m_ser - 7'd1;
        bus.req_ser = ts; bus.req_par = m_par; bus.req_valid = 1'b1;
        for (int o = 0; o <= 7; o++) begin
            @(negedge clk);
            if (o == 0) bus.req_valid = 1'b0;
        end
        checks++;
        if (bus.enableSer !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_strobe got %b exp 1", bus.enableSer);
        end
        #2 rst = 1'b1;
        #1;
        got = {bus.tuningCodeSer, bus.tuningCodePar, bus.enableSer, bus.enablePar, bus.done, bus.busy, bus.req_ready, 1'b0};
        checks++;
        if (got !== {7'd0, 7'd0, 6'b000010}) begin
            errors++;
            $display("FAIL rst_async got %h exp %h", got, {7'd0, 7'd0, 6'b000010});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int o = 0; o < 20; o++) begin
            @(negedge clk);
            got = {bus.tuningCodeSer, bus.tuningCodePar, bus.enableSer, bus.enablePar, bus.done, bus.busy, bus.req_ready, 1'b0};
            checks++;
            if (got !== {7'd0, 7'd0, 6'b000010}) begin
                errors++;
                $display("FAIL rst_after cyc%0d got %h exp %h", o, got, {7'd0, 7'd0, 6'b000010});
            end
        end
        m_ser = 7'd0; m_par = 7'd0;
    endtask

    task automatic test_strobe_zero();
        logic [16:0] got;
        logic [16:0] exp;
        int last;
        int en_cnt;
        int n;
        plan(7'd0, 7'd0, 7'd127, 7'd0);
        n = q_s.size();
        last = n * (1 + S + 1 + H);
        en_cnt = 0;
        bz.req_ser = 7'd127; bz.req_par = 7'd0; bz.req_valid = 1'b1;
        for (int o = 0; o <= last + 2; o++) begin
            @(negedge clk);
            if (o == 0) bz.req_valid = 1'b0;
            if (bz.enableSer === 1'b1) en_cnt++;
            got = {bz.tuningCodeSer, bz.tuningCodePar, bz.enableSer, bz.enablePar, bz.done};
            exp = expect_at(o, S, 0, H, 7'd0, 7'd0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL zero cyc%0d got %h exp %h", o, got, exp);
            end
        end
        checks++;
        if (en_cnt !== n) begin
            errors++;
            $display("FAIL zero_en_cycles got %0d exp %0d", en_cnt, n);
        end
        bz.req_ser = 7'd127; bz.req_par = 7'd0; bz.req_valid = 1'b1;
        for (int o = 0; o <= 2; o++) begin
            @(negedge clk);
            if (o == 0) bz.req_valid = 1'b0;
            got = {bz.tuningCodeSer, bz.tuningCodePar, bz.enableSer, bz.enablePar, bz.done};
            exp = {7'd127, 7'd0, 1'b0, 1'b0, (o == 1)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL zero_top cyc%0d got %h exp %h", o, got, exp);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_ser = 7'd0; bus.req_par = 7'd0;
        bz.req_valid  = 1'b0; bz.req_ser  = 7'd0; bz.req_par  = 7'd0;
        test_reset();
        @(negedge clk);
        test_null();
        test_single_step();
        test_ignored();
`ifdef CAP_ENC_SLEW_EN
        test_slew();
`endif
        test_back_to_back();
        @(negedge clk);
        test_reset_mid_strobe();
        test_strobe_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
